// File: rtl/systolic_output_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : systolic_output_collector_pkg
// Description : Shared definitions for the systolic output collector: collector
//               FSM state encodings and the row-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package systolic_output_collector_pkg;

  // Width of the job row counter and of the requested row count.
  localparam int unsigned c_ROW_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/systolic_col_fifo.sv
`default_nettype none
// ============================================================================
// Module      : systolic_col_fifo
// Description : Per-column de-skew FIFO. Power-of-two depth, pointers carry one
//               extra bit so full and empty are told apart. Storage is not
//               reset; only the pointers are.
// Ports       : clk, rst_n      - clock, asynchronous active-low reset
//               flush           - synchronous empty (pointers to zero)
//               push / din      - write request and data
//               pop             - read request (advances the head)
//               dout            - current head entry
//               full / empty    - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_col_fifo #(
  parameter int WIDTH = 23,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW:0]    r_wptr;
  logic [c_AW:0]    r_rptr;
  logic             w_wr;
  logic             w_rd;

  // A push into a full FIFO is accepted only when the head leaves this cycle.
  assign w_wr = push && (!full || pop);
  assign w_rd = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr && !flush) r_mem[r_wptr[c_AW-1:0]] <= din;
  end

  assign dout  = r_mem[r_rptr[c_AW-1:0]];
  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                 (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);

endmodule
`default_nettype wire

// File: rtl/systolic_output_collector.sv
`default_nettype none
// ============================================================================
// Module      : systolic_output_collector
// Description : Re-aligns skewed per-column results of a systolic array into
//               full rows. Each column feeds its own de-skew FIFO; a row is
//               presented once every FIFO holds an entry and all heads pop
//               together on the output handshake.
// Ports       : clk, rst_n            - clock, asynchronous active-low reset
//               i_start, i_num_rows   - job start pulse and row count
//               i_data, i_valid       - skewed column results / per-column valid
//               o_data, o_valid       - aligned row / row available
//               i_ready               - downstream accepts the row
//               o_last                - final row of the job
//               o_done                - one-cycle job-complete pulse
//               o_busy                - job in progress
//               o_overflow            - sticky: a column push was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_output_collector
  import systolic_output_collector_pkg::*;
#(
  parameter int NUM_COL        = 8,
  parameter int OUT_DATA_WIDTH = 23,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_start,
  input  logic [c_ROW_CNT_W-1:0]            i_num_rows,
  input  logic [NUM_COL*OUT_DATA_WIDTH-1:0] i_data,
  input  logic [NUM_COL-1:0]                i_valid,
  output logic [NUM_COL*OUT_DATA_WIDTH-1:0] o_data,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic                              o_last,
  output logic                              o_done,
  output logic                              o_busy,
  output logic                              o_overflow
);

  state_t                            r_state;
  state_t                            w_state_nxt;
  logic [c_ROW_CNT_W-1:0]            r_row_cnt;
  logic [c_ROW_CNT_W-1:0]            r_num_rows;
  logic                              r_overflow;

  logic [NUM_COL-1:0]                w_push;
  logic [NUM_COL-1:0]                w_full;
  logic [NUM_COL-1:0]                w_empty;
  logic [NUM_COL-1:0]                w_col_ovf;
  logic [NUM_COL*OUT_DATA_WIDTH-1:0] w_heads;
  logic                              w_flush;
  logic                              w_valid;
  logic                              w_hs;
  logic                              w_pop;
  logic                              w_last;

  // A start is honoured in IDLE and (as a restart) in COLLECT, never in DONE.
  // An honoured start also empties every column FIFO.
  assign w_flush = i_start && (r_state != DONE);
  assign w_valid = &(~w_empty);
  assign w_hs    = w_valid && i_ready;
  // The restart cycle discards the FIFO contents, so no head is consumed.
  assign w_pop   = w_hs && !w_flush;
  assign w_last  = w_valid && (r_row_cnt == (r_num_rows - c_ROW_CNT_W'(1)));

  for (genvar c = 0; c < NUM_COL; c++) begin : g_col
    // Pushes are only taken while collecting and never in a restart cycle.
    assign w_push[c]    = (r_state == COLLECT) && !i_start && i_valid[c];
    assign w_col_ovf[c] = w_push[c] && w_full[c] && !w_pop;

    systolic_col_fifo #(
      .WIDTH (OUT_DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (w_flush),
      .push  (w_push[c]),
      .pop   (w_pop),
      .din   (i_data[c*OUT_DATA_WIDTH +: OUT_DATA_WIDTH]),
      .dout  (w_heads[c*OUT_DATA_WIDTH +: OUT_DATA_WIDTH]),
      .full  (w_full[c]),
      .empty (w_empty[c])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (i_start) w_state_nxt = (i_num_rows == '0) ? DONE : COLLECT;
      end
      COLLECT: begin
        if (i_start)            w_state_nxt = (i_num_rows == '0) ? DONE : COLLECT;
        else if (w_hs && w_last) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_cnt  <= '0;
      r_num_rows <= '0;
      r_overflow <= 1'b0;
    end else if (w_flush) begin
      r_row_cnt  <= '0;
      r_num_rows <= i_num_rows;
      r_overflow <= 1'b0;
    end else begin
      if ((r_state == COLLECT) && w_hs) r_row_cnt <= r_row_cnt + 1'b1;
      if (|w_col_ovf)                   r_overflow <= 1'b1;
    end
  end

  // FIFO storage is never reset, so the heads are masked whenever no full row
  // is present; this keeps o_data at zero during and after reset.
  assign o_data     = w_valid ? w_heads : '0;
  assign o_valid    = w_valid;
  assign o_last     = w_last;
  assign o_done     = (r_state == DONE);
  assign o_busy     = (r_state == COLLECT);
  assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_systolic_output_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_output_collector
// Description : Directed self-checking bench for systolic_output_collector
//               with default parameters (8 columns, 23-bit results, depth 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_output_collector;

  localparam int NC = 8;
  localparam int W  = 23;
  localparam int DW = NC * W;

  logic          clk;
  logic          rst_n;
  logic          i_start;
  logic [15:0]   i_num_rows;
  logic [DW-1:0] i_data;
  logic [NC-1:0] i_valid;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          i_ready;
  logic          o_last;
  logic          o_done;
  logic          o_busy;
  logic          o_overflow;

  int checks;
  int errors;

  systolic_output_collector #(
    .NUM_COL        (NC),
    .OUT_DATA_WIDTH (W),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (i_start),
    .i_num_rows (i_num_rows),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_last     (o_last),
    .o_done     (o_done),
    .o_busy     (o_busy),
    .o_overflow (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Row with column c holding base + c*16 + r.
  function automatic logic [DW-1:0] mkrow(input int base, input int r);
    logic [DW-1:0] v;
    v = '0;
    for (int c = 0; c < NC; c++) v[c*W +: W] = W'(base + c*16 + r);
    return v;
  endfunction

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    i_start    = 1'b0;
    i_num_rows = '0;
    i_data     = '0;
    i_valid    = '0;
    i_ready    = 1'b0;

    // ---------------- reset state ----------------
    #3;
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_ovf", o_overflow, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // pushes in IDLE are ignored
    i_valid = '1;
    i_data  = mkrow(0, 0);
    tick();
    i_valid = '0;
    chk("idle_push_valid", o_valid, 0);
    chk("idle_busy", o_busy, 0);
    tick();

    // ---------------- skewed job, 3 rows ----------------
    i_num_rows = 16'd3;
    i_ready    = 1'b1;
    i_start    = 1'b1;
    tick();
    i_start = 1'b0;
    for (int k = 0; k < 13; k++) begin
      logic [NC-1:0] v;
      v = '0;
      for (int c = 0; c < NC; c++) begin
        if (k - c >= 0 && k - c < 3) v[c] = 1'b1;
        i_data[c*W +: W] = W'(c*16 + k - c);
      end
      i_valid = v;
      chk("s1_valid", o_valid, (k >= 8 && k <= 10));
      if (k >= 8 && k <= 10) chk("s1_data", o_data, mkrow(0, k - 8));
      chk("s1_last", o_last, (k == 10));
      chk("s1_done", o_done, (k == 11));
      chk("s1_busy", o_busy, (k <= 10));
      tick();
    end
    i_valid = '0;

    // ---------------- backpressure, 3 rows pending ----------------
    i_num_rows = 16'd3;
    i_ready    = 1'b0;
    i_start    = 1'b1;
    tick();
    i_start = 1'b0;
    for (int r = 0; r < 3; r++) begin
      i_valid = '1;
      i_data  = mkrow('h100, r);
      chk("s2_fill_valid", o_valid, (r > 0));
      tick();
    end
    i_valid = '0;
    for (int s = 0; s < 10; s++) begin
      chk("s2_stall_valid", o_valid, 1);
      chk("s2_stall_data", o_data, mkrow('h100, 0));
      chk("s2_stall_ovf", o_overflow, 0);
      tick();
    end
    i_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      chk("s2_rel_valid", o_valid, 1);
      chk("s2_rel_data", o_data, mkrow('h100, r));
      chk("s2_rel_last", o_last, (r == 2));
      tick();
    end
    chk("s2_done", o_done, 1);
    chk("s2_done_valid", o_valid, 0);
    tick();

    // ---------------- overflow on column 0 ----------------
    i_num_rows = 16'd4;
    i_ready    = 1'b0;
    i_start    = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      i_valid = 8'h01;
      i_data  = mkrow('h10, i);
      chk("s3_ovf_before", o_overflow, 0);
      tick();
    end
    chk("s3_ovf_set", o_overflow, 1);
    for (int i = 0; i < 4; i++) begin
      i_valid = 8'hFE;
      i_data  = mkrow('h40, i);
      tick();
    end
    i_valid = '0;
    i_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      chk("s3_valid", o_valid, 1);
      chk("s3_col0", o_data[0 +: W], W'('h10 + r));
      chk("s3_col1", o_data[W +: W], W'('h50 + r));
      chk("s3_last", o_last, (r == 3));
      chk("s3_ovf_sticky", o_overflow, 1);
      tick();
    end
    chk("s3_done", o_done, 1);
    tick();
    chk("s3_ovf_idle", o_overflow, 1);

    // ---------------- zero-row job ----------------
    i_num_rows = 16'd0;
    i_start    = 1'b1;
    tick();
    i_start = 1'b0;
    chk("s4_done", o_done, 1);
    chk("s4_valid", o_valid, 0);
    chk("s4_busy", o_busy, 0);
    chk("s4_ovf_clr", o_overflow, 0);
    tick();
    chk("s4_done_end", o_done, 0);
    chk("s4_valid_end", o_valid, 0);

    // ---------------- restart after 1 of 4 rows ----------------
    i_num_rows = 16'd4;
    i_ready    = 1'b1;
    i_start    = 1'b1;
    tick();
    i_start = 1'b0;
    i_valid = '1;
    i_data  = mkrow('h300, 0);
    chk("s5_c0_valid", o_valid, 0);
    tick();
    i_data = mkrow('h300, 1);
    chk("s5_c1_data", o_data, mkrow('h300, 0));
    tick();
    i_start    = 1'b1;
    i_num_rows = 16'd2;
    i_data     = mkrow('h300, 2);
    chk("s5_c2_data", o_data, mkrow('h300, 1));
    tick();
    i_start = 1'b0;
    i_data  = mkrow('h500, 0);
    chk("s5_flush_valid", o_valid, 0);
    chk("s5_flush_busy", o_busy, 1);
    tick();
    i_data = mkrow('h500, 1);
    chk("s5_n0_data", o_data, mkrow('h500, 0));
    chk("s5_n0_last", o_last, 0);
    tick();
    i_valid = '0;
    chk("s5_n1_data", o_data, mkrow('h500, 1));
    chk("s5_n1_last", o_last, 1);
    tick();
    chk("s5_done", o_done, 1);
    tick();

    // ---------------- asynchronous reset mid-job ----------------
    i_num_rows = 16'd2;
    i_ready    = 1'b0;
    i_start    = 1'b1;
    tick();
    i_start = 1'b0;
    i_valid = '1;
    i_data  = mkrow('h700, 0);
    tick();
    i_data = mkrow('h700, 1);
    tick();
    i_valid = '0;
    chk("s6_pre_valid", o_valid, 1);
    chk("s6_pre_busy", o_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_rst_valid", o_valid, 0);
    chk("s6_rst_data", o_data, 0);
    chk("s6_rst_busy", o_busy, 0);
    chk("s6_rst_done", o_done, 0);
    chk("s6_rst_last", o_last, 0);
    chk("s6_rst_ovf", o_overflow, 0);
    tick();
    chk("s6_rst_done2", o_done, 0);
    rst_n = 1'b1;
    tick();
    chk("s6_idle_done", o_done, 0);
    chk("s6_idle_busy", o_busy, 0);
    chk("s6_idle_valid", o_valid, 0);
    i_num_rows = 16'd1;
    i_ready    = 1'b1;
    i_start    = 1'b1;
    tick();
    i_start = 1'b0;
    i_valid = '1;
    i_data  = mkrow('h20, 0);
    tick();
    i_valid = '0;
    chk("s6_job_data", o_data, mkrow('h20, 0));
    chk("s6_job_last", o_last, 1);
    tick();
    chk("s6_job_done", o_done, 1);
    tick();
    chk("s6_job_idle", o_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/systolic_output_collector.md
SYSTOLIC_OUTPUT_COLLECTOR -- requirements
Module: systolic_output_collector

Interface
REQ-001 SHALL have parameter NUM_COL, default 8: number of array columns.
REQ-002 SHALL have parameter OUT_DATA_WIDTH, default 23: per-column result width, equal to (DATA_WIDTH<<1)+NUM_ROW-1 for DATA_WIDTH=8 and NUM_ROW=8.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4 (power of two, >=2): per-column de-skew buffer depth.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port i_start, input, 1 bit: one-cycle pulse that loads i_num_rows and arms collection.
REQ-007 SHALL have port i_num_rows, input, 16 bits: number of result rows expected in the job.
REQ-008 SHALL have port i_data, input, NUM_COL*OUT_DATA_WIDTH bits: skewed column results from the array output pipe; column c occupies [c*OUT_DATA_WIDTH +: OUT_DATA_WIDTH].
REQ-009 SHALL have port i_valid, input, NUM_COL bits: per-column result valid.
REQ-010 SHALL have port o_data, output, NUM_COL*OUT_DATA_WIDTH bits: aligned result row.
REQ-011 SHALL have port o_valid, output, 1 bit: o_data holds a complete row.
REQ-012 SHALL have port i_ready, input, 1 bit: downstream accepts the row.
REQ-013 SHALL have port o_last, output, 1 bit: qualifies the final row of the job.
REQ-014 SHALL have port o_done, output, 1 bit: one-cycle job-complete pulse.
REQ-015 SHALL have port o_busy, output, 1 bit: high while in state COLLECT.
REQ-016 SHALL have port o_overflow, output, 1 bit: sticky error flag.

Function
REQ-017 SHALL implement FSM states IDLE, COLLECT and DONE: IDLE->COLLECT on i_start with i_num_rows!=0; IDLE->DONE on i_start with i_num_rows==0; COLLECT->DONE on the handshake of the last row; DONE->IDLE unconditionally after one cycle.
REQ-018 SHALL, in COLLECT, push i_data column c into column FIFO c in every cycle that i_valid[c]=1; pushes SHALL be ignored in IDLE and DONE.
REQ-019 SHALL assert o_valid combinationally when all NUM_COL FIFOs are non-empty; o_data SHALL be the concatenation of the FIFO heads.
REQ-020 SHALL give a latency of 1 cycle: a row becomes visible the cycle after the push of its latest-arriving column.
REQ-021 SHALL pop all FIFOs together on o_valid&&i_ready; o_data SHALL hold stable while o_valid=1 and i_ready=0.
REQ-022 SHALL allow a simultaneous push and pop on the same FIFO, including a full FIFO; occupancy is then unchanged and no overflow is raised.
REQ-023 SHALL, on a push to a full FIFO without a pop, drop the data and set o_overflow; o_overflow SHALL clear only on i_start or reset.
REQ-024 SHALL use a 16-bit row counter that increments per handshake; o_last=o_valid&&(row_cnt==num_rows-1).
REQ-025 SHALL pulse o_done for exactly the one cycle spent in DONE.
REQ-026 SHALL treat i_start in COLLECT as a restart: flush all FIFOs, clear row_cnt and o_overflow, load i_num_rows, and ignore any push in the same cycle.
REQ-027 SHALL ignore i_start in DONE.
REQ-028 SHALL wrap FIFO pointers modulo FIFO_DEPTH; full/empty SHALL be distinguished by an extra pointer bit.

Reset
REQ-029 SHALL, while rst_n=0, enter IDLE, empty all FIFOs, and zero row_cnt, num_rows, o_overflow, o_done, o_busy, o_valid, o_last and o_data, independent of clk.
REQ-030 SHALL, when reset is asserted mid-job, discard the job with no o_done; after deassertion it SHALL wait in IDLE for i_start.

Structure
REQ-031 SHALL place the state encodings (IDLE=2'd0, COLLECT=2'd1, DONE=2'd2) and the row-counter width (16) in the shared systolic package.
REQ-032 SHALL instantiate one sub-module, systolic_col_fifo (parameters WIDTH and DEPTH; ports push, pop, din, dout, full, empty), NUM_COL times via generate; FIFO storage SHALL NOT be reset.

Verification
REQ-033 SHALL cover: start with num_rows=3, columns 0..7 arriving skewed by 1 cycle each, data c*16+r, i_ready=1 -> three rows on o_valid, last push cycle +1, o_last on row 2, then o_done the next cycle.
REQ-034 SHALL cover: i_ready=0 for 10 cycles mid-job with FIFO_DEPTH=4 and 3 rows pending -> o_data stable, no overflow, rows delivered in order after release.
REQ-035 SHALL cover: 5 pushes to column 0 with i_ready=0 and other columns idle -> o_overflow=1 on the 5th push, first 4 values retained.
REQ-036 SHALL cover: i_start with num_rows=0 -> o_done one cycle later, o_valid never asserted.
REQ-037 SHALL cover: restart i_start after 1 of 4 rows, with a simultaneous push -> FIFOs flushed, push ignored, new job completes with the correct count.
REQ-038 SHALL cover: rst_n low mid-job between clock edges -> all outputs 0 immediately, no o_done, next job runs cleanly.
